pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Registered, parametrised program-counter unit; the next generation of the combinational next-PC selector.
- Holds the PC and computes PC+4 and branch, jump and register-jump targets.
- Adds stall, a latched interrupt request with EPC save, an interrupt-enable state, and exception return (eret).
- Sits at the head of the fetch stage; its pc output drives instruction-memory address.

Parameters:
- WIDTH, 32, PC/datapath width; legal range 32..64.
- RESET_VEC, 32'h0040_0000, PC value on reset (zero-extended to WIDTH).
- INT_VEC, 32'h8000_0180, handler entry address (zero-extended to WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold PC, EPC and ie this cycle
- branch  input  1  instruction is a conditional branch
- zero  input  1  ALU zero flag
- imm  input  WIDTH  sign-extended branch offset, in words
- jump  input  1  j/jal
- jTarget  input  26  jump index field
- jr  input  1  jump-register
- jrAddr  input  WIDTH  register jump target
- int_req  input  1  interrupt request, level or single-cycle pulse
- eret  input  1  return from handler
- pc  output  WIDTH  current PC (registered)
- pcp4  output  WIDTH  pc+4, combinational, mod 2^WIDTH
- epc  output  WIDTH  saved return address (registered)
- in_handler  output  1  equals ~ie (registered)
- int_ack  output  1  one-cycle registered pulse when an interrupt is taken

Behaviour:
Clocking and reset:
- One clock domain.
- rst_n low forces immediately: pc=RESET_VEC, epc=0, ie=1, pend=0, int_ack=0.
- Any in-flight pending request is discarded on reset.

Target arithmetic (all mod 2^WIDTH):
- bTarget = pcp4 + (imm << 2).
- jTgt = {pcp4[WIDTH-1:28], jTarget, 2'b00}.
- rTgt = {jrAddr[WIDTH-1:2], 2'b00}; the low two bits are forced to zero.

Sequential target (seqNext), priority order:
1. eret && in_handler -> epc
2. jr -> rTgt
3. jump -> jTgt
4. branch && zero -> bTarget
5. otherwise -> pcp4
- eret while not in_handler is ignored; lower-priority controls apply.

Interrupt latch:
- pend is set on any edge where int_req=1, including stalled cycles.
- pend is cleared only when the interrupt is taken.

Each rising edge with stall=1:
- pc, epc and ie hold.
- int_ack=0.
- pend still samples int_req.

Each rising edge with stall=0:
- If (pend or int_req) and ie, the interrupt is taken:
  - epc <= seqNext, i.e. the PC the interrupted program would have fetched; branch, jump and jr are honoured.
  - pc <= INT_VEC, ie <= 0, pend <= 0, int_ack <= 1.
- Otherwise:
  - pc <= seqNext, int_ack <= 0.
  - If eret was honoured, ie <= 1.

Boundary cases:
- Request during handler (ie=0): it stays pending and is taken on the first non-stalled edge after eret completes. epc then receives the target that follows eret, so there is no lost return.
- eret and pend simultaneously: eret wins; the interrupt is taken on the next non-stalled edge.
- Nested interrupts are not supported; epc is never overwritten while in_handler=1.
- PC wrap at 2^WIDTH-4: pcp4=0, no flag.
- Latency: control inputs affect pc one edge later; pcp4 follows pc combinationally.

Test Plan:
- Reset then 3 non-stalled edges, all controls 0 -> pc 00400000, 00400004, 00400008, 0040000C; epc=0, in_handler=0.
- At pc=00400010: branch=1, zero=1, imm=FFFFFFFE -> next pc 0040000C. Same with zero=0 -> 00400014.
- At pc=00400020: jump=1, jTarget=0x0100040 -> pc 00400100. Then jr=1, jrAddr=00400203 -> pc 00400200.
- int_req pulse at pc=00400040 together with jump to 00400100:
  - next pc 80000180, epc 00400100, int_ack=1 for exactly one cycle, in_handler=1.
  - Later eret -> pc 00400100, in_handler=0.
- int_req during handler, held with stall=1 over the eret cycle:
  - pc holds while stalled.
  - After eret: pc=epc, then the following edge pc=80000180 with epc = epc+4.
- rst_n asserted mid-handler with pend=1 -> pc=00400000 immediately without a clock edge, in_handler=0, no int_ack after release.
- WIDTH=64 instance at pc=FFFFFFFF_FFFFFFFC -> pcp4=0, next pc 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Registered program counter with branch/jump/jr targets, stall,
// a latched interrupt request with EPC save, and exception return.
module pc_sequencer #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h0040_0000,
    parameter logic [31:0] INT_VEC   = 32'h8000_0180
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch,
    input  logic             zero,
    input  logic [WIDTH-1:0] imm,
    input  logic             jump,
    input  logic [25:0]      jTarget,
    input  logic             jr,
    input  logic [WIDTH-1:0] jrAddr,
    input  logic             int_req,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pcp4,
    output logic [WIDTH-1:0] epc,
    output logic             in_handler,
    output logic             int_ack
);

    localparam logic [WIDTH-1:0] LP_RESET = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] LP_INT   = WIDTH'(INT_VEC);

    typedef enum logic {
        S_RUN,
        S_HANDLER
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic             r_pend;
    logic             r_ack;

    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_epc_nxt;
    logic             w_pend_nxt;
    logic             w_ack_nxt;

    logic [WIDTH-1:0] w_pcp4;
    logic [WIDTH-1:0] w_btgt;
    logic [WIDTH-1:0] w_jtgt;
    logic [WIDTH-1:0] w_rtgt;
    logic [WIDTH-1:0] w_seq;
    logic             w_ie;
    logic             w_eret_ok;
    logic             w_int_ok;

    assign w_ie      = (r_state == S_RUN);
    assign w_eret_ok = eret & ~w_ie;
    assign w_int_ok  = (r_pend | int_req) & w_ie;

    assign w_pcp4 = r_pc + WIDTH'(4);
    assign w_btgt = w_pcp4 + (imm << 2);
    assign w_jtgt = {w_pcp4[WIDTH-1:28], jTarget, 2'b00};
    assign w_rtgt = {jrAddr[WIDTH-1:2], 2'b00};

    always_comb begin
        w_seq = w_pcp4;
        priority case (1'b1)
            w_eret_ok:       w_seq = r_epc;
            jr:              w_seq = w_rtgt;
            jump:            w_seq = w_jtgt;
            (branch & zero): w_seq = w_btgt;
            default:         w_seq = w_pcp4;
        endcase
    end

    // A stalled edge freezes pc/epc/ie but still latches a request.
    always_comb begin
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend | int_req;
        w_ack_nxt   = 1'b0;
        if (!stall) begin
            if (w_int_ok) begin
                w_pc_nxt    = LP_INT;
                w_epc_nxt   = w_seq;
                w_state_nxt = S_HANDLER;
                w_pend_nxt  = 1'b0;
                w_ack_nxt   = 1'b1;
            end else begin
                w_pc_nxt = w_seq;
                if (w_eret_ok) begin
                    w_state_nxt = S_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= LP_RESET;
            r_epc   <= '0;
            r_state <= S_RUN;
            r_pend  <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_epc   <= w_epc_nxt;
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    assign pc         = r_pc;
    assign pcp4       = w_pcp4;
    assign epc        = r_epc;
    assign in_handler = (r_state == S_HANDLER);
    assign int_ack    = r_ack;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random stimulus
// against a spec-level model; also a WIDTH=64 wrap instance.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [31:0] imm;
    logic        jump;
    logic [25:0] jTarget;
    logic        jr;
    logic [31:0] jrAddr;
    logic        int_req;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [31:0] epc;
    logic        in_handler;
    logic        int_ack;

    logic        jr64;
    logic [63:0] jrAddr64;
    logic [63:0] pc64;
    logic [63:0] pcp4_64;
    logic [63:0] epc64;
    logic        inh64;
    logic        ack64;

    int total;
    int bad;

    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_ie;
    bit          m_pend;
    bit          m_ack;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch(branch), .zero(zero), .imm(imm),
        .jump(jump), .jTarget(jTarget), .jr(jr),
        .jrAddr(jrAddr), .int_req(int_req), .eret(eret),
        .pc(pc), .pcp4(pcp4), .epc(epc),
        .in_handler(in_handler), .int_ack(int_ack)
    );

    pc_sequencer #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .stall(1'b0),
        .branch(1'b0), .zero(1'b0), .imm(64'd0),
        .jump(1'b0), .jTarget(26'd0), .jr(jr64),
        .jrAddr(jrAddr64), .int_req(1'b0), .eret(1'b0),
        .pc(pc64), .pcp4(pcp4_64), .epc(epc64),
        .in_handler(inh64), .int_ack(ack64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        stall = 0; branch = 0; zero = 0; imm = 0;
        jump = 0; jTarget = 0; jr = 0; jrAddr = 0;
        int_req = 0; eret = 0;
    endtask

    task automatic model_reset();
        m_pc = 32'h0040_0000; m_epc = 0;
        m_ie = 1; m_pend = 0; m_ack = 0;
    endtask

    // One clock edge; the model advances from the inputs held before it.
    task automatic step();
        logic [31:0] p4;
        logic [31:0] seq;
        bit          eok;
        bit          take;
        p4  = m_pc + 32'd4;
        eok = eret && !m_ie;
        if (eok)               seq = m_epc;
        else if (jr)           seq = jrAddr & 32'hFFFF_FFFC;
        else if (jump)         seq = {p4[31:28], jTarget, 2'b00};
        else if (branch && zero) seq = p4 + imm * 32'd4;
        else                   seq = p4;
        take = !stall && (m_pend || int_req) && m_ie;
        @(posedge clk);
        #1;
        if (stall) begin
            m_ack = 0;
            if (int_req) m_pend = 1;
        end else if (take) begin
            m_epc = seq; m_pc = 32'h8000_0180;
            m_ie = 0; m_pend = 0; m_ack = 1;
        end else begin
            m_pc = seq; m_ack = 0;
            if (eok) m_ie = 1;
            if (int_req) m_pend = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); jr64 = 0; jrAddr64 = 0;
        #12;
        total += 5;
        if (pc !== 32'h0040_0000) begin
            bad++; $display("FAIL rst_pc got=%h want=00400000", pc);
        end
        if (pcp4 !== 32'h0040_0004) begin
            bad++; $display("FAIL rst_pcp4 got=%h want=00400004", pcp4);
        end
        if (epc !== 32'h0) begin
            bad++; $display("FAIL rst_epc got=%h want=0", epc);
        end
        if (in_handler !== 1'b0 || int_ack !== 1'b0) begin
            bad++; $display("FAIL rst_flags got=%b%b want=00", in_handler, int_ack);
        end
        if (pc64 !== 64'h0040_0000) begin
            bad++; $display("FAIL rst_pc64 got=%h want=400000", pc64);
        end
        model_reset();
        rst_n = 1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h0040_0004, 32'h0040_0008, 32'h0040_000C, 32'h0040_0010};
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (pc !== exp_pc[i] || epc !== 0 || in_handler !== 0) begin
                bad++;
                $display("FAIL seq%0d pc=%h epc=%h inh=%b want pc=%h epc=0 inh=0",
                         i, pc, epc, in_handler, exp_pc[i]);
            end
        end
    endtask

    task automatic test_branch();
        branch = 1; zero = 1; imm = 32'hFFFF_FFFE;
        step();
        total++;
        if (pc !== 32'h0040_000C) begin
            bad++; $display("FAIL br_taken got=%h want=0040000C", pc);
        end
        idle();
        step();
        branch = 1; zero = 0; imm = 32'hFFFF_FFFE;
        step();
        total++;
        if (pc !== 32'h0040_0014) begin
            bad++; $display("FAIL br_not_taken got=%h want=00400014", pc);
        end
        idle();
    endtask

    task automatic test_jump_jr();
        jr = 1; jrAddr = 32'h0040_0020;
        step();
        idle();
        jump = 1; jTarget = 26'h010_0040;
        step();
        total++;
        if (pc !== 32'h0040_0100) begin
            bad++; $display("FAIL jump got=%h want=00400100", pc);
        end
        idle();
        jr = 1; jrAddr = 32'h0040_0203; jump = 1; jTarget = 26'h3;
        step();
        total++;
        if (pc !== 32'h0040_0200) begin
            bad++; $display("FAIL jr got=%h want=00400200", pc);
        end
        idle();
    endtask

    task automatic test_interrupt();
        jr = 1; jrAddr = 32'h0040_0040;
        step();
        idle();
        int_req = 1; jump = 1; jTarget = 26'h010_0040;
        step();
        idle();
        total += 2;
        if (pc !== 32'h8000_0180 || epc !== 32'h0040_0100) begin
            bad++; $display("FAIL int_take pc=%h epc=%h want 80000180/00400100", pc, epc);
        end
        if (int_ack !== 1'b1 || in_handler !== 1'b1) begin
            bad++; $display("FAIL int_flags ack=%b inh=%b want 1/1", int_ack, in_handler);
        end
        step();
        total++;
        if (int_ack !== 1'b0 || pc !== 32'h8000_0184) begin
            bad++; $display("FAIL int_ack_pulse ack=%b pc=%h want 0/80000184", int_ack, pc);
        end
        eret = 1;
        step();
        idle();
        total++;
        if (pc !== 32'h0040_0100 || in_handler !== 1'b0) begin
            bad++; $display("FAIL eret pc=%h inh=%b want 00400100/0", pc, in_handler);
        end
    endtask

    task automatic test_int_in_handler();
        int_req = 1;
        step();
        idle();
        total++;
        if (pc !== 32'h8000_0180 || epc !== 32'h0040_0104) begin
            bad++; $display("FAIL nest_enter pc=%h epc=%h want 80000180/00400104", pc, epc);
        end
        int_req = 1; stall = 1; eret = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (pc !== 32'h8000_0180 || in_handler !== 1 || int_ack !== 0) begin
                bad++; $display("FAIL stall_hold%0d pc=%h inh=%b ack=%b", i, pc, in_handler, int_ack);
            end
        end
        stall = 0; int_req = 0;
        step();
        eret = 0;
        total++;
        if (pc !== 32'h0040_0104 || in_handler !== 0) begin
            bad++; $display("FAIL nest_eret pc=%h inh=%b want 00400104/0", pc, in_handler);
        end
        step();
        total++;
        if (pc !== 32'h8000_0180 || epc !== 32'h0040_0108 || int_ack !== 1) begin
            bad++; $display("FAIL pend_take pc=%h epc=%h ack=%b want 80000180/00400108/1",
                            pc, epc, int_ack);
        end
        eret = 1;
        step();
        idle();
    endtask

    task automatic test_async_reset();
        int_req = 1;
        step();
        step();
        idle();
        #2;
        rst_n = 0;
        #1;
        total++;
        if (pc !== 32'h0040_0000 || in_handler !== 0 || epc !== 0 || int_ack !== 0) begin
            bad++; $display("FAIL async_rst pc=%h inh=%b epc=%h ack=%b", pc, in_handler, epc, int_ack);
        end
        model_reset();
        rst_n = 1;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if (int_ack !== 0 || pc !== 32'h0040_0000 + 32'(4 * i)) begin
                bad++; $display("FAIL post_rst%0d pc=%h ack=%b", i, pc, int_ack);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            stall   = ($urandom_range(3) == 0);
            int_req = ($urandom_range(7) == 0);
            eret    = ($urandom_range(5) == 0);
            jr      = ($urandom_range(9) == 0);
            jump    = ($urandom_range(9) == 0);
            branch  = ($urandom_range(3) == 0);
            zero    = $urandom_range(1);
            imm     = $urandom;
            jTarget = 26'($urandom);
            jrAddr  = $urandom;
            step();
            total++;
            if (pc !== m_pc || pcp4 !== m_pc + 32'd4 || epc !== m_epc
                || in_handler !== !m_ie || int_ack !== m_ack) begin
                bad++;
                $display("FAIL rand%0d pc=%h epc=%h inh=%b ack=%b want pc=%h epc=%h inh=%b ack=%b",
                         n, pc, epc, in_handler, int_ack, m_pc, m_epc, !m_ie, m_ack);
            end
        end
        idle();
    endtask

    task automatic test_wrap64();
        jr64 = 1; jrAddr64 = 64'hFFFF_FFFF_FFFF_FFFC;
        @(posedge clk);
        #1;
        jr64 = 0;
        total += 2;
        if (pc64 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            bad++; $display("FAIL wrap_pc64 got=%h want=FFFFFFFFFFFFFFFC", pc64);
        end
        if (pcp4_64 !== 64'd0) begin
            bad++; $display("FAIL wrap_pcp4 got=%h want=0", pcp4_64);
        end
        @(posedge clk);
        #1;
        total++;
        if (pc64 !== 64'd0 || pcp4_64 !== 64'd4) begin
            bad++; $display("FAIL wrap_next pc=%h pcp4=%h want 0/4", pc64, pcp4_64);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump_jr();
        test_interrupt();
        test_int_in_handler();
        test_async_reset();
        test_random();
        test_wrap64();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
